// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: shifts one half-row bit-plane out of the
// framebuffer, latches it, then shows it for a binary-weighted (BCM) time.
module hub75_scan_ctrl #(
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int BITDEPTH_MAX   = 8,
  parameter int CTRL_REG_WIDTH = 32,
  parameter int BCM_BASE       = 16,
  parameter int R_ADDR_WIDTH   = $clog2(N_ROWS_MAX*N_COLS_MAX)-1
) (
  input  logic                              r_clk,
  input  logic                              rst_n,
  input  logic                              ctrl_enable,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_cols,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_bitdepth,
  input  logic                              swap_req,
  output logic                              swap_ack,
  output logic                              fb_r_en,
  output logic                              fb_r_buffer,
  output logic [R_ADDR_WIDTH-1:0]           fb_r_addr,
  output logic [$clog2(BITDEPTH_MAX)-1:0]   fb_r_bit,
  input  logic [5:0]                        fb_r_dout,
  output logic                              hub_clk,
  output logic                              hub_lat,
  output logic                              hub_oe_n,
  output logic [$clog2(N_ROWS_MAX)-2:0]     hub_addr,
  output logic [5:0]                        hub_rgb
);

  localparam int BIT_W   = $clog2(BITDEPTH_MAX);
  localparam int ROW_W   = $clog2(N_ROWS_MAX) - 1;
  localparam int BD_W    = $clog2(BITDEPTH_MAX + 1);
  localparam int COL_W   = $clog2(N_COLS_MAX + 1);
  localparam int HALF_W  = $clog2(N_ROWS_MAX/2 + 1);
  localparam int SHIFT_W = $clog2(2*N_COLS_MAX + 1);
  localparam int DISP_W  = $clog2(BCM_BASE) + BITDEPTH_MAX;
  localparam int CNT_W   = (SHIFT_W > DISP_W) ? SHIFT_W : DISP_W;
  localparam int AI_W    = R_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [AI_W-1:0]   row_base_q, row_base_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [COL_W-1:0]  cols_q, cols_d;
  logic [BD_W-1:0]   bd_q, bd_d;
  logic              buf_q, buf_d;
  logic              ack_q, ack_d;
  logic [5:0]        rgb_q, rgb_d;
  logic [ROW_W-1:0]  haddr_q, haddr_d;
  logic              arm_q, arm_d;

  logic              ctrl_ok;
  logic [BD_W-1:0]   bd_in;
  logic [CNT_W-1:0]  shift_last;
  logic [CNT_W-1:0]  disp_last;
  logic              last_bit;
  logic              last_row;

  assign ctrl_ok = ctrl_enable && (ctrl_n_rows >= CTRL_REG_WIDTH'(2))
                   && (ctrl_n_cols >= CTRL_REG_WIDTH'(1));
  assign bd_in = (ctrl_bitdepth == '0) ? BD_W'(1) :
                 (ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX)) ? BD_W'(BITDEPTH_MAX) :
                 BD_W'(ctrl_bitdepth);

  assign shift_last = CNT_W'({cols_q, 1'b0});
  assign disp_last  = (CNT_W'(BCM_BASE) << bit_q) - CNT_W'(1);
  assign last_bit   = (BD_W'(bit_q) + BD_W'(1)) == bd_q;
  assign last_row   = (HALF_W'(row_q) + HALF_W'(1)) == half_q;

  // Strobes decode straight from the async-reset state so OE blanks the
  // instant rst_n falls, without waiting for a clock edge.
  assign fb_r_en     = (state_q == SHIFT) && !cnt_q[0] && (cnt_q != shift_last);
  assign fb_r_addr   = fb_r_en ? R_ADDR_WIDTH'(row_base_q + AI_W'(cnt_q >> 1)) : '0;
  assign fb_r_bit    = bit_q;
  assign fb_r_buffer = buf_q;
  assign hub_clk     = (state_q == SHIFT) && !cnt_q[0] && (cnt_q != '0);
  assign hub_lat     = (state_q == LATCH);
  assign hub_oe_n    = (state_q != DISPLAY);
  assign hub_addr    = haddr_q;
  assign hub_rgb     = rgb_q;
  assign swap_ack    = ack_q;

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      bit_q      <= '0;
      row_base_q <= '0;
      half_q     <= '0;
      cols_q     <= '0;
      bd_q       <= '0;
      buf_q      <= 1'b0;
      ack_q      <= 1'b0;
      rgb_q      <= '0;
      haddr_q    <= '0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      bit_q      <= bit_d;
      row_base_q <= row_base_d;
      half_q     <= half_d;
      cols_q     <= cols_d;
      bd_q       <= bd_d;
      buf_q      <= buf_d;
      ack_q      <= ack_d;
      rgb_q      <= rgb_d;
      haddr_q    <= haddr_d;
      arm_q      <= arm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    bit_d      = bit_q;
    row_base_d = row_base_q;
    half_d     = half_q;
    cols_d     = cols_q;
    bd_d       = bd_q;
    buf_d      = buf_q;
    ack_d      = 1'b0;
    rgb_d      = rgb_q;
    haddr_d    = haddr_q;
    arm_d      = 1'b1;
    case (state_q)
      IDLE: begin
        // arm_q holds off the first scan until the second edge after reset.
        if (arm_q && ctrl_ok) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          row_d      = '0;
          bit_d      = '0;
          row_base_d = '0;
          half_d     = HALF_W'(ctrl_n_rows >> 1);
          cols_d     = COL_W'(ctrl_n_cols);
          bd_d       = bd_in;
        end
      end
      SHIFT: begin
        if (cnt_q[0]) rgb_d = fb_r_dout;
        if (cnt_q == shift_last) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLANK: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = LATCH;
          cnt_d   = '0;
          haddr_d = row_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        cnt_d   = '0;
      end
      DISPLAY: begin
        if (cnt_q == disp_last) begin
          cnt_d = '0;
          if (!last_bit) begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = SHIFT;
          end else if (!last_row) begin
            bit_d      = '0;
            row_d      = row_q + ROW_W'(1);
            row_base_d = row_base_q + AI_W'(cols_q);
            state_d    = SHIFT;
          end else begin
            bit_d      = '0;
            row_d      = '0;
            row_base_d = '0;
            if (swap_req) begin
              buf_d = !buf_q;
              ack_d = 1'b1;
            end
            if (ctrl_ok) begin
              state_d = SHIFT;
              half_d  = HALF_W'(ctrl_n_rows >> 1);
              cols_d  = COL_W'(ctrl_n_cols);
              bd_d    = bd_in;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: a negedge monitor logs reads, shifted
// pixels, latches and OE-low run lengths; tests compare them to hand values.
module tb_hub75_scan_ctrl;

  logic        r_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_enable = 1'b0;
  logic [31:0] ctrl_n_rows = 32'd4;
  logic [31:0] ctrl_n_cols = 32'd4;
  logic [31:0] ctrl_bitdepth = 32'd2;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        fb_r_en;
  logic        fb_r_buffer;
  logic [12:0] fb_r_addr;
  logic [2:0]  fb_r_bit;
  logic [5:0]  fb_r_dout = '0;
  logic        hub_clk;
  logic        hub_lat;
  logic        hub_oe_n;
  logic [4:0]  hub_addr;
  logic [5:0]  hub_rgb;

  int checks = 0;
  int failures = 0;

  int addr_log[$];
  int bit_log[$];
  int rgb_log[$];
  int lat_log[$];
  int oe_runs[$];
  int oe_len = 0;
  int ack_pulses = 0;
  int ack_cycles = 0;
  logic prev_clk = 1'b0;
  logic prev_ack = 1'b0;
  logic [4:0] prev_addr = '0;
  logic [5:0] prev_rgb = '0;
  logic clr = 1'b1;

  hub75_scan_ctrl #(.BCM_BASE(4)) dut (
    .r_clk(r_clk), .rst_n(rst_n), .ctrl_enable(ctrl_enable),
    .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols), .ctrl_bitdepth(ctrl_bitdepth),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .fb_r_en(fb_r_en), .fb_r_buffer(fb_r_buffer), .fb_r_addr(fb_r_addr),
    .fb_r_bit(fb_r_bit), .fb_r_dout(fb_r_dout),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_addr(hub_addr), .hub_rgb(hub_rgb)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [5:0] pat(input int a, input logic b);
    logic [5:0] v;
    v = 6'(a * 5 + 3);
    return b ? ~v : v;
  endfunction

  // Framebuffer model with one cycle of read latency.
  always @(posedge r_clk) begin
    if (fb_r_en) fb_r_dout <= pat(int'(fb_r_addr), fb_r_buffer);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge r_clk) begin
    if (clr) begin
      addr_log.delete(); bit_log.delete(); rgb_log.delete();
      lat_log.delete(); oe_runs.delete();
      oe_len = 0; ack_pulses = 0; ack_cycles = 0;
      prev_clk = 1'b0; prev_ack = 1'b0;
    end else begin
      if (fb_r_en) begin
        addr_log.push_back(int'(fb_r_addr));
        bit_log.push_back(int'(fb_r_bit));
      end
      if (hub_clk && !prev_clk) rgb_log.push_back(int'(hub_rgb));
      if (hub_lat) begin
        lat_log.push_back(int'(hub_addr));
        check_eq("lat_oe_n", 32'(hub_oe_n), 32'd1);
      end
      if (!hub_oe_n) oe_len++;
      else if (oe_len > 0) begin
        oe_runs.push_back(oe_len);
        oe_len = 0;
      end
      if (swap_ack) ack_cycles++;
      if (swap_ack && !prev_ack) ack_pulses++;
      if (rst_n && !hub_lat) check_eq("addr_hold", 32'(hub_addr), 32'(prev_addr));
      if (rst_n && !hub_oe_n) check_eq("rgb_hold", 32'(hub_rgb), 32'(prev_rgb));
      prev_clk = hub_clk;
      prev_ack = swap_ack;
    end
    prev_addr = hub_addr;
    prev_rgb  = hub_rgb;
  end

  task automatic tick();
    @(posedge r_clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_oe_n", 32'(hub_oe_n), 32'd1);
    check_eq("rst_fb_en", 32'(fb_r_en), 32'd0);
    check_eq("rst_fb_addr", 32'(fb_r_addr), 32'd0);
    check_eq("rst_fb_bit", 32'(fb_r_bit), 32'd0);
    check_eq("rst_fb_buf", 32'(fb_r_buffer), 32'd0);
    check_eq("rst_hub_clk", 32'(hub_clk), 32'd0);
    check_eq("rst_hub_lat", 32'(hub_lat), 32'd0);
    check_eq("rst_hub_addr", 32'(hub_addr), 32'd0);
    check_eq("rst_hub_rgb", 32'(hub_rgb), 32'd0);
    check_eq("rst_swap_ack", 32'(swap_ack), 32'd0);
  endtask

  task automatic wait_runs(input int n, input int budget, input string tag);
    int k = 0;
    while (oe_runs.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(oe_runs.size()), 32'(n));
  endtask

  task automatic wait_first_read(input string tag);
    int k = 0;
    while (addr_log.size() == 0 && k < 40) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(addr_log.size() > 0), 32'd1);
  endtask

  task automatic check_idle(input int runs, input string tag);
    int sz;
    sz = addr_log.size();
    repeat (30) tick();
    check_eq({tag, "_no_reads"}, 32'(addr_log.size()), 32'(sz));
    check_eq({tag, "_runs"}, 32'(oe_runs.size()), 32'(runs));
    check_eq({tag, "_oe_n"}, 32'(hub_oe_n), 32'd1);
  endtask

  initial begin
    int idx;
    int maxb;
    #2;
    check_reset_outputs();

    // Basic 4x4, 2 bit-planes; enable dropped and cols changed mid-frame.
    ctrl_n_rows = 4; ctrl_n_cols = 4; ctrl_bitdepth = 2; ctrl_enable = 1'b1;
    do_reset();
    tick();
    check_eq("post_rst_edge1_en", 32'(fb_r_en), 32'd0);
    wait_first_read("t1_start");
    ctrl_enable = 1'b0;
    ctrl_n_cols = 8;
    wait_runs(4, 600, "t1_frame_runs");
    check_idle(4, "t1_idle");
    check_eq("t1_nreads", 32'(addr_log.size()), 32'd16);
    check_eq("t1_nclk", 32'(rgb_log.size()), 32'd16);
    idx = 0;
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < 4; c++) begin
          check_eq("t1_addr", (idx < addr_log.size()) ? 32'(addr_log[idx]) : 32'hFFFF_FFFF, 32'(r*4 + c));
          check_eq("t1_bit", (idx < bit_log.size()) ? 32'(bit_log[idx]) : 32'hFFFF_FFFF, 32'(b));
          check_eq("t1_rgb", (idx < rgb_log.size()) ? 32'(rgb_log[idx]) : 32'hFFFF_FFFF, 32'(pat(r*4 + c, 1'b0)));
          idx++;
        end
        check_eq("t1_lat_addr", (r*2+b < lat_log.size()) ? 32'(lat_log[r*2+b]) : 32'hFFFF_FFFF, 32'(r));
        check_eq("t1_oe_len", (r*2+b < oe_runs.size()) ? 32'(oe_runs[r*2+b]) : 32'hFFFF_FFFF, 32'(4 << b));
      end
    end
    check_eq("t1_nlat", 32'(lat_log.size()), 32'd4);

    // Buffer swap: request mid-frame, then hold it across frames.
    ctrl_n_rows = 4; ctrl_n_cols = 4; ctrl_bitdepth = 1; ctrl_enable = 1'b1; swap_req = 1'b0;
    do_reset();
    begin
      int k = 0;
      while (lat_log.size() == 0 && k < 100) begin tick(); k++; end
    end
    check_eq("t2_first_lat", 32'(lat_log.size()), 32'd1);
    swap_req = 1'b1;
    tick();
    check_eq("t2_buf_mid", 32'(fb_r_buffer), 32'd0);
    check_eq("t2_ack_mid", 32'(ack_pulses), 32'd0);
    wait_runs(2, 200, "t2_f1");
    check_eq("t2_ack_f1", 32'(ack_pulses), 32'd1);
    check_eq("t2_buf_f1", 32'(fb_r_buffer), 32'd1);
    wait_runs(4, 200, "t2_f2");
    check_eq("t2_ack_f2", 32'(ack_pulses), 32'd2);
    check_eq("t2_buf_f2", 32'(fb_r_buffer), 32'd0);
    wait_runs(6, 200, "t2_f3");
    check_eq("t2_ack_f3", 32'(ack_pulses), 32'd3);
    check_eq("t2_buf_f3", 32'(fb_r_buffer), 32'd1);
    swap_req = 1'b0;
    ctrl_enable = 1'b0;
    wait_runs(8, 200, "t2_f4");
    check_idle(8, "t2_idle");
    check_eq("t2_ack_f4", 32'(ack_pulses), 32'd3);
    check_eq("t2_buf_f4", 32'(fb_r_buffer), 32'd1);
    check_eq("t2_ack_single", 32'(ack_cycles), 32'(ack_pulses));

    // Reset asserted while the panel is lit.
    ctrl_n_rows = 4; ctrl_n_cols = 4; ctrl_bitdepth = 2; ctrl_enable = 1'b1;
    do_reset();
    begin
      int k = 0;
      while (hub_oe_n && k < 100) begin tick(); k++; end
    end
    check_eq("t3_reached_display", 32'(hub_oe_n), 32'd0);
    tick();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    clr = 1'b1;
    repeat (2) tick();
    clr = 1'b0;
    rst_n = 1'b1;
    wait_runs(1, 200, "t3_restart_run");
    check_eq("t3_first_lat", (lat_log.size() > 0) ? 32'(lat_log[0]) : 32'hFFFF_FFFF, 32'd0);
    check_eq("t3_first_addr", (addr_log.size() > 0) ? 32'(addr_log[0]) : 32'hFFFF_FFFF, 32'd0);
    check_eq("t3_first_bit", (bit_log.size() > 0) ? 32'(bit_log[0]) : 32'hFFFF_FFFF, 32'd0);
    check_eq("t3_first_oe", (oe_runs.size() > 0) ? 32'(oe_runs[0]) : 32'hFFFF_FFFF, 32'd4);
    ctrl_enable = 1'b0;
    wait_runs(4, 600, "t3_frame_runs");
    check_idle(4, "t3_idle");

    // Bitdepth 0 is treated as a single plane.
    ctrl_n_rows = 4; ctrl_n_cols = 1; ctrl_bitdepth = 0; ctrl_enable = 1'b1;
    do_reset();
    wait_first_read("t4a_start");
    ctrl_enable = 1'b0;
    wait_runs(2, 200, "t4a_runs");
    check_idle(2, "t4a_idle");
    check_eq("t4a_nlat", 32'(lat_log.size()), 32'd2);
    check_eq("t4a_oe0", 32'(oe_runs[0]), 32'd4);
    check_eq("t4a_oe1", 32'(oe_runs[1]), 32'd4);

    // Bitdepth 12 clamps to 8 planes.
    ctrl_bitdepth = 12; ctrl_enable = 1'b1;
    do_reset();
    wait_first_read("t4b_start");
    ctrl_enable = 1'b0;
    wait_runs(16, 4000, "t4b_runs");
    check_idle(16, "t4b_idle");
    check_eq("t4b_nlat", 32'(lat_log.size()), 32'd16);
    check_eq("t4b_oe7", 32'(oe_runs[7]), 32'd512);
    check_eq("t4b_oe8", 32'(oe_runs[8]), 32'd4);
    check_eq("t4b_oe15", 32'(oe_runs[15]), 32'd512);
    maxb = 0;
    foreach (bit_log[i]) if (bit_log[i] > maxb) maxb = bit_log[i];
    check_eq("t4b_max_bit", 32'(maxb), 32'd7);

    // A single-row panel is not scannable.
    ctrl_n_rows = 1; ctrl_n_cols = 4; ctrl_bitdepth = 2; ctrl_enable = 1'b1;
    do_reset();
    repeat (40) tick();
    check_eq("t5_no_reads", 32'(addr_log.size()), 32'd0);
    check_eq("t5_no_lat", 32'(lat_log.size()), 32'd0);
    check_eq("t5_oe_n", 32'(hub_oe_n), 32'd1);
    ctrl_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 SHALL have parameter N_ROWS_MAX, default 64, total panel rows.
REQ-002 SHALL have parameter N_COLS_MAX, default 256, chained columns.
REQ-003 SHALL have parameter BITDEPTH_MAX, default 8, bits per color.
REQ-004 SHALL have parameter CTRL_REG_WIDTH, default 32, width of each ctrl input.
REQ-005 SHALL have parameter BCM_BASE, default 16, OE-on cycles for bit 0.
REQ-006 SHALL have parameter R_ADDR_WIDTH, default $clog2(N_ROWS_MAX*N_COLS_MAX)-1, framebuffer read address width.
REQ-007 Ports: r_clk  in  1  single clock, all logic on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-008 Ports: ctrl_enable  in  1  scan enable; ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth  in  CTRL_REG_WIDTH  active geometry.
REQ-009 Ports: swap_req  in  1  level request to flip buffers; swap_ack  out  1  one-cycle pulse on flip.
REQ-010 Ports: fb_r_en  out  1; fb_r_buffer  out  1; fb_r_addr  out  R_ADDR_WIDTH; fb_r_bit  out  $clog2(BITDEPTH_MAX); fb_r_dout  in  6  {R0,G0,B0,R1,G1,B1}, valid one cycle after fb_r_en.
REQ-011 Ports: hub_clk, hub_lat, hub_oe_n  out  1; hub_addr  out  $clog2(N_ROWS_MAX)-1; hub_rgb  out  6.

Function
REQ-012 SHALL use states IDLE, SHIFT, BLANK, LATCH, DISPLAY.
REQ-013 IDLE -> SHIFT when ctrl_enable=1 and ctrl_n_rows>=2 and ctrl_n_cols>=1; SHALL latch ctrl values into shadow regs on this transition only.
REQ-014 Shadow bitdepth 0 SHALL be treated as 1; values >BITDEPTH_MAX SHALL clamp to BITDEPTH_MAX.
REQ-015 Scan half-rows = n_rows/2 (floor); row r in 0..half-1, bit b in 0..bitdepth-1, column c in 0..n_cols-1.
REQ-016 SHIFT, column c: fb_r_en=1 and fb_r_addr=r*n_cols+c at SHIFT cycle 2c; hub_rgb<=fb_r_dout with hub_clk=0 at cycle 2c+1; hub_clk=1 at cycle 2c+2 (column c+1 address also issued that cycle); fb_r_bit=b throughout.
REQ-017 After last column's hub_clk high cycle, SHIFT -> BLANK; hub_clk=0, fb_r_en=0 outside SHIFT.
REQ-018 BLANK: hub_oe_n=1 for exactly 2 cycles, then LATCH.
REQ-019 LATCH: one cycle, hub_lat=1, hub_addr<=r, hub_oe_n=1; then DISPLAY.
REQ-020 DISPLAY: hub_oe_n=0 for exactly BCM_BASE<<b cycles, then advance: b+1; on b wrap to 0, r+1; on r wrap, frame end.
REQ-021 hub_addr SHALL change only in LATCH; hub_rgb SHALL change only in SHIFT.
REQ-022 Frame end with swap_req=1: fb_r_buffer SHALL toggle and swap_ack SHALL pulse 1 cycle; with swap_req=0 no toggle.
REQ-023 Frame end: if ctrl_enable=1 re-latch shadows and enter SHIFT at r=0,b=0; else IDLE.
REQ-024 ctrl_enable deassert or ctrl changes mid-frame SHALL NOT affect the current frame.
REQ-025 Address arithmetic SHALL be at least R_ADDR_WIDTH+1 bits wide internally; result truncated to R_ADDR_WIDTH.
REQ-026 DISPLAY counter SHALL be wide enough for BCM_BASE<<(BITDEPTH_MAX-1) without overflow.

Reset
REQ-027 On rst_n=0 (asynchronous): state IDLE, r=b=c=0, fb_r_buffer=0, fb_r_en=0, fb_r_addr=0, fb_r_bit=0, hub_clk=0, hub_lat=0, hub_oe_n=1, hub_addr=0, hub_rgb=0, swap_ack=0.
REQ-028 Reset mid-DISPLAY SHALL force hub_oe_n=1 immediately, not on the next clock edge.
REQ-029 After rst_n rises, first SHIFT SHALL start no earlier than the second r_clk edge.

Verification
REQ-030 n_rows=4,n_cols=4,bitdepth=2,BCM_BASE=4, enable -> 4 hub_clk pulses per SHIFT; addresses 0..3 for r=0, 4..7 for r=1; OE low 4 then 8 cycles; hub_lat pulses 4 per frame.
REQ-031 Same config, fb_r_dout=address-dependent pattern -> hub_rgb at each hub_clk rise equals fb_r_dout for that column, one-cycle BRAM latency honored.
REQ-032 swap_req=1 mid-frame -> fb_r_buffer toggles only at frame end, swap_ack single pulse; swap_req held -> toggles every frame.
REQ-033 ctrl_enable=0 and ctrl_n_cols=8 mid-frame -> current frame completes with n_cols=4, then IDLE with hub_oe_n=1.
REQ-034 rst_n low during DISPLAY -> hub_oe_n=1 same cycle, all outputs at REQ-027 values, restart at r=0,b=0.
REQ-035 ctrl_bitdepth=0 and =12 (BITDEPTH_MAX=8) -> 1 and 8 bit-planes per row respectively; ctrl_n_rows=1 -> remains IDLE.
